// File: rtl/board_io_avmm_if.sv
// Avalon-MM slave bus bundle for board_io_avmm.
// master drives the request side, slave returns read data.
interface board_io_avmm_if;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata,
        output avs_readdatavalid
    );
endinterface

// File: rtl/board_io_avmm.sv
// Avalon-MM board I/O: seven-segment digits, LEDs, debounced keys.
// Define BOARD_IO_KEY_IRQ_EN for key press edge latching and irq_o.
module board_io_avmm #(
    parameter int NUM_DIGITS      = 6,
    parameter int LED_W           = 10,
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    board_io_avmm_if.slave          avs,
    input  logic [KEY_W-1:0]        key_i,
    output logic [LED_W-1:0]        led_o,
    output logic [7*NUM_DIGITS-1:0] hex_o,
    output logic                    irq_o
);
    localparam int HW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [HW-1:0]         hex_val;
    logic [NUM_DIGITS-1:0] hex_en;
    logic [LED_W-1:0]      led_q;
    logic [KEY_W-1:0]      sync_q1;
    logic [KEY_W-1:0]      sync_q2;
    logic [KEY_W-1:0]      key_q;
    logic [KEY_W-1:0]      key_nxt;
    logic [KEY_W-1:0]      pressed;
    logic [CW-1:0]         cnt_q   [KEY_W];
    logic [CW-1:0]         cnt_nxt [KEY_W];
    logic [7*NUM_DIGITS-1:0] hex_img;
    logic [31:0]           rd_val;
    logic                  wr_hv;
    logic                  wr_en;
    logic                  wr_led;
    logic                  wr_edge;
    logic                  wr_mask;
    logic                  unused_wd;

    assign unused_wd = ^avs.avs_writedata;
    assign pressed   = ~sync_q2;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            4'hF: seg7 = 7'b0001110;
        endcase
    endfunction

    // Decode the write strobe into one enable per register.
    always_comb begin
        wr_hv   = 1'b0;
        wr_en   = 1'b0;
        wr_led  = 1'b0;
        wr_edge = 1'b0;
        wr_mask = 1'b0;
        if (avs.avs_write) begin
            case (avs.avs_address)
                3'd0:    wr_hv   = 1'b1;
                3'd1:    wr_en   = 1'b1;
                3'd2:    wr_led  = 1'b1;
                3'd4:    wr_edge = 1'b1;
                3'd5:    wr_mask = 1'b1;
                default: ;
            endcase
        end
    end

    // Software-visible display and LED registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_val <= '0;
            hex_en  <= '0;
            led_q   <= '0;
        end else begin
            if (wr_hv)  hex_val <= avs.avs_writedata[HW-1:0];
            if (wr_en)  hex_en  <= avs.avs_writedata[NUM_DIGITS-1:0];
            if (wr_led) led_q   <= avs.avs_writedata[LED_W-1:0];
        end
    end

    // Segment image: enabled digits decode their nibble, others stay dark.
    always_comb begin
        hex_img = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (hex_en[i]) hex_img[7*i +: 7] = seg7(hex_val[4*i +: 4]);
        end
    end

    // Pin drivers are registered copies of the register image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_o <= '1;
            led_o <= '0;
        end else begin
            hex_o <= hex_img;
            led_o <= led_q;
        end
    end

    // Two-flop synchroniser; reset to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_i;
            sync_q2 <= sync_q1;
        end
    end

    // A key flips only after disagreeing for DEBOUNCE_CYCLES clocks.
    always_comb begin
        key_nxt = key_q;
        for (int k = 0; k < KEY_W; k++) begin
            cnt_nxt[k] = '0;
            if (pressed[k] != key_q[k]) begin
                if (cnt_q[k] == CNT_MAX) key_nxt[k] = pressed[k];
                else                     cnt_nxt[k] = cnt_q[k] + CW'(1);
            end
        end
    end

    // Debounced key state and per-key stability counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            for (int k = 0; k < KEY_W; k++) cnt_q[k] <= '0;
        end else begin
            key_q <= key_nxt;
            for (int k = 0; k < KEY_W; k++) cnt_q[k] <= cnt_nxt[k];
        end
    end

`ifdef BOARD_IO_KEY_IRQ_EN
    logic [KEY_W-1:0] key_edge;
    logic [KEY_W-1:0] irq_mask;
    logic [KEY_W-1:0] key_rise;
    logic [KEY_W-1:0] w1c;

    assign key_rise = key_nxt & ~key_q;
    assign w1c = wr_edge ? avs.avs_writedata[KEY_W-1:0] : '0;

    // Press latch with W1C; a new press in the clearing cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_edge <= '0;
            irq_mask <= '0;
            irq_o    <= 1'b0;
        end else begin
            key_edge <= (key_edge & ~w1c) | key_rise;
            if (wr_mask) irq_mask <= avs.avs_writedata[KEY_W-1:0];
            irq_o <= |(key_edge & irq_mask);
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    // Read mux over the register map; holes and unused bits read 0.
    always_comb begin
        rd_val = '0;
        case (avs.avs_address)
            3'd0: rd_val[HW-1:0]         = hex_val;
            3'd1: rd_val[NUM_DIGITS-1:0] = hex_en;
            3'd2: rd_val[LED_W-1:0]      = led_q;
            3'd3: rd_val[KEY_W-1:0]      = key_q;
`ifdef BOARD_IO_KEY_IRQ_EN
            3'd4: rd_val[KEY_W-1:0]      = key_edge;
            3'd5: rd_val[KEY_W-1:0]      = irq_mask;
`endif
            default: ;
        endcase
    end

    // Registered read response, one clock after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            avs.avs_readdata      <= avs.avs_read ? rd_val : '0;
            avs.avs_readdatavalid <= avs.avs_read;
        end
    end
endmodule

// File: tb/tb_board_io_avmm.sv
// Bench for board_io_avmm: directed checks plus random traffic
// compared every cycle against a behavioural model.
module tb_board_io_avmm;
    localparam int ND = 6;
    localparam int LW = 10;
    localparam int KW = 4;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [KW-1:0] key_i = '1;
    logic [LW-1:0] led_o;
    logic [7*ND-1:0] hex_o;
    logic irq_o;

    board_io_avmm_if bus ();

    board_io_avmm #(
        .NUM_DIGITS(ND), .LED_W(LW), .KEY_W(KW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .avs(bus.slave), .key_i(key_i),
        .led_o(led_o), .hex_o(hex_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    logic [4*ND-1:0] m_hv;
    logic [ND-1:0]   m_en;
    logic [LW-1:0]   m_led_reg, m_led;
    logic [7*ND-1:0] m_hex;
    logic [KW-1:0]   m_raw1, m_raw2, m_key, m_edge, m_mask;
    logic            m_irq, m_rvalid;
    logic [31:0]     m_rdata;
    int              run [KW];

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
            4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
            4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
            4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
            4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
            4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
            4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
            4'hE: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        logic [31:0] r = '0;
        case (a)
            3'd0: r[4*ND-1:0] = m_hv;
            3'd1: r[ND-1:0] = m_en;
            3'd2: r[LW-1:0] = m_led_reg;
            3'd3: r[KW-1:0] = m_key;
`ifdef BOARD_IO_KEY_IRQ_EN
            3'd4: r[KW-1:0] = m_edge;
            3'd5: r[KW-1:0] = m_mask;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model state advances at each clock; async reset mirrors rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hv = '0; m_en = '0; m_led_reg = '0; m_led = '0;
            m_hex = '1; m_raw1 = '1; m_raw2 = '1; m_key = '0;
            m_edge = '0; m_mask = '0; m_irq = 1'b0;
            m_rvalid = 1'b0; m_rdata = '0;
            for (int k = 0; k < KW; k++) run[k] = 0;
        end else begin
            logic [KW-1:0] rise;
            m_rvalid = bus.avs_read;
            m_rdata = bus.avs_read ? model_reg(bus.avs_address) : '0;
            for (int i = 0; i < ND; i++)
                m_hex[7*i +: 7] = m_en[i] ? seg_code(m_hv[4*i +: 4]) : 7'h7F;
            m_led = m_led_reg;
`ifdef BOARD_IO_KEY_IRQ_EN
            m_irq = |(m_edge & m_mask);
`endif
            // pin level seen two clocks late; accept after DB disagreeing clocks
            rise = '0;
            for (int k = 0; k < KW; k++) begin
                if (!m_raw2[k] != m_key[k]) begin
                    run[k]++;
                    if (run[k] == DB) begin
                        m_key[k] = !m_raw2[k];
                        rise[k] = m_key[k];
                        run[k] = 0;
                    end
                end else run[k] = 0;
            end
            m_raw2 = m_raw1;
            m_raw1 = key_i;
            if (bus.avs_write) begin
                case (bus.avs_address)
                    3'd0: m_hv = bus.avs_writedata[4*ND-1:0];
                    3'd1: m_en = bus.avs_writedata[ND-1:0];
                    3'd2: m_led_reg = bus.avs_writedata[LW-1:0];
`ifdef BOARD_IO_KEY_IRQ_EN
                    3'd4: m_edge = m_edge & ~bus.avs_writedata[KW-1:0];
                    3'd5: m_mask = bus.avs_writedata[KW-1:0];
`endif
                    default: ;
                endcase
            end
`ifdef BOARD_IO_KEY_IRQ_EN
            m_edge = m_edge | rise;
`endif
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic step();
        @(negedge clk);
        chk("hex_o", 64'(hex_o), 64'(m_hex));
        chk("led_o", 64'(led_o), 64'(m_led));
        chk("irq_o", 64'(irq_o), 64'(m_irq));
        chk("rvalid", 64'(bus.avs_readdatavalid), 64'(m_rvalid));
        if (m_rvalid) chk("readdata", 64'(bus.avs_readdata), 64'(m_rdata));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
        step();
        bus.avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.avs_address = a; bus.avs_read = 1'b1;
        step();
        bus.avs_read = 1'b0;
        chk("read_valid", 64'(bus.avs_readdatavalid), 64'd1);
        d = bus.avs_readdata;
    endtask

    logic [31:0] rd;
    int first;

    initial begin
        bus.avs_address = '0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0; bus.avs_read = 1'b0;
        steps(3);
        rst_n = 1'b1;
        steps(2);
        chk("rst_hex", 64'(hex_o), 64'({7*ND{1'b1}}));
        chk("rst_led", 64'(led_o), 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        bus_read(3'd3, rd);
        chk("rst_key", 64'(rd), 64'd0);

        bus_write(3'd0, 32'h00A5F3);
        bus_write(3'd1, 32'h3F);
        step();
        chk("hex_all", 64'(hex_o), 64'({7'b1000000, 7'b1000000,
            7'b0001000, 7'b0010010, 7'b0001110, 7'b0110000}));
        bus_write(3'd1, 32'h01);
        step();
        chk("hex_d0", 64'(hex_o), 64'({{5{7'h7F}}, 7'b0110000}));

        bus_write(3'd2, 32'hFFFF_FFFF);
        step();
        chk("led_all", 64'(led_o), 64'h3FF);
        bus_read(3'd2, rd);
        chk("led_rd", 64'(rd), 64'h3FF);
        bus_read(3'd7, rd);
        chk("unmapped", 64'(rd), 64'd0);

        // glitch shorter than DB
        key_i[1] = 1'b0;
        steps(10);
        key_i[1] = 1'b1;
        steps(30);
        bus_read(3'd3, rd);
        chk("glitch", 64'(rd), 64'd0);

        // long press: KEY flips 18 clocks after the fall, read adds one
        bus.avs_address = 3'd3; bus.avs_read = 1'b1;
        key_i[1] = 1'b0;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (first == 0 && bus.avs_readdata == 32'h2) first = n;
        end
        chk("press_lat", 64'(first), 64'd19);
        key_i[1] = 1'b1;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (first == 0 && bus.avs_readdata == 32'h0) first = n;
        end
        chk("release_lat", 64'(first), 64'd19);
        bus.avs_read = 1'b0;

`ifdef BOARD_IO_KEY_IRQ_EN
        bus_write(3'd5, 32'h2);
        key_i[1] = 1'b0;
        steps(25);
        step();
        chk("irq_set", 64'(irq_o), 64'd1);
        bus_read(3'd4, rd);
        chk("edge_set", 64'(rd), 64'h2);
        bus_write(3'd4, 32'h2);
        key_i[1] = 1'b1;
        steps(25);
        key_i[1] = 1'b0;
        steps(17);
        bus_write(3'd4, 32'h2);
        bus_read(3'd4, rd);
        chk("set_wins", 64'(rd), 64'h2);
        chk("irq_hold", 64'(irq_o), 64'd1);
        bus_write(3'd4, 32'h2);
        step();
        chk("irq_clr", 64'(irq_o), 64'd0);
        key_i[1] = 1'b1;
        steps(25);
`endif

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.avs_read = ($urandom_range(9) < 3);
            bus.avs_write = ($urandom_range(9) < 3);
            bus.avs_address = 3'($urandom_range(7));
            bus.avs_writedata = $urandom;
            if ($urandom_range(39) == 0)
                key_i[$urandom_range(KW-1)] ^= 1'b1;
            step();
        end
        bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        key_i = '1;
        steps(40);

        // async reset mid-debounce
        bus_write(3'd2, 32'h155);
        step();
        chk("led_155", 64'(led_o), 64'h155);
        key_i[0] = 1'b0;
        steps(8);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_led", 64'(led_o), 64'd0);
        chk("arst_hex", 64'(hex_o), 64'({7*ND{1'b1}}));
        chk("arst_irq", 64'(irq_o), 64'd0);
        chk("arst_rv", 64'(bus.avs_readdatavalid), 64'd0);
        key_i[0] = 1'b1;
        steps(3);
        rst_n = 1'b1;
        steps(2);
        bus_read(3'd3, rd);
        chk("post_rst_key", 64'(rd), 64'd0);
        steps(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
